// File: rtl/bus_key_uart_responder.sv
// bus_key_uart_responder: key FIFO with interrupt, key/status loads, and an 8N1 UART transmitter behind the CPU bus
// Ports: clk, reset (async active-low); bus_address/bus_write_data/bus_write_enable/bus_read_enable in,
// bus_read_data out (registered); interrupt_vector out, interrupt_ack in; key_valid/key_data in; uart_tx out (idles high).
module bus_key_uart_responder #(
   parameter logic [63:0] KEY_BASE     = 64'h0000_0000_1000_0000,
   parameter logic [63:0] ART_BASE     = 64'h0000_0000_1000_0008,
   parameter int          FIFO_DEPTH   = 4,
   parameter int          CLKS_PER_BIT = 434
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] bus_address,
   input  logic [63:0] bus_write_data,
   input  logic        bus_write_enable,
   input  logic        bus_read_enable,
   output logic [63:0] bus_read_data,
   output logic [3:0]  interrupt_vector,
   input  logic        interrupt_ack,
   input  logic        key_valid,
   input  logic [7:0]  key_data,
   output logic        uart_tx
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

   logic          prev_rd, prev_wr, rd_acc, wr_acc, key_hit, art_hit;
   logic [7:0]    wr_byte;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0]   count;
   logic          key_ovr, tx_ovr, armed;
   logic          pop, push, key_drop, status_rd, tx_start, tx_drop, tx_busy, tick;
   tx_state_t     state, state_n;
   logic [BW-1:0] baud, baud_n;
   logic [2:0]    bit_idx, bit_n;
   logic [7:0]    tx_byte;
   logic          tx_n;
   logic          unused;

   assign unused = ^bus_write_data[63:8];

   // first-cycle detection is registered, so an access seen at one edge acts on the next
   assign pop       = rd_acc & key_hit & (count != '0);
   assign push      = key_valid & ((count != FULL) | pop);
   assign key_drop  = key_valid & ~push;
   assign status_rd = rd_acc & art_hit;
   assign tx_busy   = state != IDLE;
   assign tx_start  = wr_acc & art_hit & ~tx_busy;
   assign tx_drop   = wr_acc & art_hit & tx_busy;
   assign tick      = baud == BAUD_LAST;

   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= key_data;

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         prev_rd          <= 1'b0;
         prev_wr          <= 1'b0;
         rd_acc           <= 1'b0;
         wr_acc           <= 1'b0;
         key_hit          <= 1'b0;
         art_hit          <= 1'b0;
         wr_byte          <= '0;
         rd_ptr           <= '0;
         wr_ptr           <= '0;
         count            <= '0;
         key_ovr          <= 1'b0;
         tx_ovr           <= 1'b0;
         armed            <= 1'b1;
         bus_read_data    <= '0;
         interrupt_vector <= '0;
      end else begin
         prev_rd          <= bus_read_enable;
         prev_wr          <= bus_write_enable;
         rd_acc           <= bus_read_enable & ~prev_rd;
         wr_acc           <= bus_write_enable & ~prev_wr;
         key_hit          <= bus_address == KEY_BASE;
         art_hit          <= bus_address == ART_BASE;
         wr_byte          <= bus_write_data[7:0];
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count            <= count + (AW+1)'(push) - (AW+1)'(pop);
         // a new overflow in the same cycle as a status read survives the clear
         key_ovr          <= (key_ovr & ~status_rd) | key_drop;
         tx_ovr           <= (tx_ovr & ~status_rd) | tx_drop;
         armed            <= pop | (armed & ~interrupt_ack);
         interrupt_vector <= {3'b0, (count != '0) & armed};
         if (rd_acc & key_hit) bus_read_data <= pop ? {55'b0, 1'b1, mem[rd_ptr]} : '0;
         else if (status_rd) bus_read_data <= {53'b0, 3'(count), 5'b0, tx_ovr, key_ovr, tx_busy};
      end

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state   <= IDLE;
         baud    <= '0;
         bit_idx <= '0;
         tx_byte <= '0;
         uart_tx <= 1'b1;
      end else begin
         state   <= state_n;
         baud    <= baud_n;
         bit_idx <= bit_n;
         uart_tx <= tx_n;
         if (tx_start) tx_byte <= wr_byte;
      end

   // uart_tx is registered from the next state so the line changes together with the state
   always_comb begin
      state_n = state;
      baud_n  = (state == IDLE || tick) ? '0 : baud + 1'b1;
      bit_n   = (state == IDLE) ? 3'd0 : bit_idx;
      case (state)
         IDLE:    if (tx_start) state_n = START;
         START:   if (tick) state_n = DATA;
         DATA:    if (tick) begin
                     bit_n = bit_idx + 3'd1;
                     if (bit_idx == 3'd7) state_n = STOP;
                  end
         STOP:    if (tick) state_n = IDLE;
         default: state_n = IDLE;
      endcase
      tx_n = (state_n == DATA) ? tx_byte[bit_n] : (state_n != START);
   end
endmodule

// File: tb/tb_bus_key_uart_responder.sv
// tb_bus_key_uart_responder: directed and random stimulus checked against a queue/timeline model of the responder
module tb_bus_key_uart_responder;
   localparam logic [63:0] KEY = 64'h0000_0000_1000_0000;
   localparam logic [63:0] ART = 64'h0000_0000_1000_0008;
   localparam logic [63:0] OTH = 64'h0000_0000_1000_0010;
   localparam int DEPTH = 4;
   localparam int CPB = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [63:0] bus_address = '0;
   logic [63:0] bus_write_data = '0;
   logic        bus_write_enable = 1'b0;
   logic        bus_read_enable = 1'b0;
   logic [63:0] bus_read_data;
   logic [3:0]  interrupt_vector;
   logic        interrupt_ack = 1'b0;
   logic        key_valid = 1'b0;
   logic [7:0]  key_data = '0;
   logic        uart_tx;

   int vectors = 0;
   int miscompares = 0;

   bus_key_uart_responder #(.KEY_BASE(KEY), .ART_BASE(ART), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .reset(reset), .bus_address(bus_address), .bus_write_data(bus_write_data),
      .bus_write_enable(bus_write_enable), .bus_read_enable(bus_read_enable), .bus_read_data(bus_read_data),
      .interrupt_vector(interrupt_vector), .interrupt_ack(interrupt_ack), .key_valid(key_valid),
      .key_data(key_data), .uart_tx(uart_tx)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
      end
   endtask

   // behavioural model: byte queue, sticky flags, and a frame timeline indexed by edge count
   logic [7:0]  q[$];
   logic        m_key_ovr, m_tx_ovr, m_armed, m_prev_rd, m_prev_wr;
   logic        p_rd, p_wr, p_key, p_art, m_tx_on, m_tx;
   logic [7:0]  p_byte, m_txbyte;
   int          cyc, m_txs;
   logic [63:0] m_rdata;
   logic [3:0]  m_vec;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         q.delete();
         m_key_ovr = 0; m_tx_ovr = 0; m_armed = 1; m_prev_rd = 0; m_prev_wr = 0;
         p_rd = 0; p_wr = 0; p_key = 0; p_art = 0; p_byte = 0; m_tx_on = 0; m_txbyte = 0;
         cyc = 0; m_txs = 0; m_rdata = 0; m_vec = 0; m_tx = 1;
      end else begin : step
         int k;
         logic busy, pop;
         cyc++;
         busy = m_tx_on && (cyc - m_txs) >= 1 && (cyc - m_txs) <= 10 * CPB;
         pop = p_rd && p_key && q.size() != 0;
         m_vec = (q.size() != 0 && m_armed) ? 4'd1 : 4'd0;
         if (p_rd && p_key) m_rdata = pop ? {55'b0, 1'b1, q[0]} : 64'b0;
         else if (p_rd && p_art) begin
            m_rdata = {53'b0, 3'(q.size()), 5'b0, m_tx_ovr, m_key_ovr, busy};
            m_tx_ovr = 0;
            m_key_ovr = 0;
         end
         if (pop) void'(q.pop_front());
         if (key_valid) begin
            if (q.size() < DEPTH) q.push_back(key_data);
            else m_key_ovr = 1;
         end
         if (p_wr && p_art) begin
            if (busy) m_tx_ovr = 1;
            else begin
               m_tx_on = 1;
               m_txs = cyc;
               m_txbyte = p_byte;
            end
         end
         if (interrupt_ack) m_armed = 0;
         if (pop) m_armed = 1;
         k = cyc - m_txs;
         m_tx = (!m_tx_on || k >= 10 * CPB) ? 1'b1 : (k < CPB) ? 1'b0 : (k >= 9 * CPB) ? 1'b1 : m_txbyte[3'(k / CPB - 1)];
         p_rd = bus_read_enable && !m_prev_rd;
         p_wr = bus_write_enable && !m_prev_wr;
         m_prev_rd = bus_read_enable;
         m_prev_wr = bus_write_enable;
         p_key = bus_address == KEY;
         p_art = bus_address == ART;
         p_byte = bus_write_data[7:0];
      end
   end

   always @(negedge clk)
      if (reset) begin
         chk("rdata", bus_read_data, m_rdata);
         chk("vector", {60'b0, interrupt_vector}, {60'b0, m_vec});
         chk("uart_tx", {63'b0, uart_tx}, {63'b0, m_tx});
      end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic rd(input logic [63:0] a, output logic [63:0] d);
      @(negedge clk); bus_address = a; bus_read_enable = 1;
      @(negedge clk);
      @(negedge clk); d = bus_read_data; bus_read_enable = 0;
   endtask

   task automatic wr(input logic [63:0] a, input logic [7:0] b);
      @(negedge clk); bus_address = a; bus_write_data = {56'b0, b}; bus_write_enable = 1;
      @(negedge clk);
      @(negedge clk); bus_write_enable = 0;
   endtask

   task automatic push(input logic [7:0] b);
      @(negedge clk); key_valid = 1; key_data = b;
      @(negedge clk); key_valid = 0;
   endtask

   initial begin
      logic [63:0] d;
      logic [9:0]  frame;
      @(negedge clk);
      chk("rst_rdata", bus_read_data, 64'h0);
      chk("rst_vector", {60'b0, interrupt_vector}, 64'h0);
      chk("rst_uart", {63'b0, uart_tx}, 64'h1);
      reset = 1;
      rd(ART, d); chk("rst_status", d, 64'h0);
      // key path
      @(negedge clk); key_valid = 1; key_data = 8'h41;
      @(negedge clk); key_valid = 0;
      @(negedge clk); chk("key_irq", {60'b0, interrupt_vector}, 64'h1);
      @(negedge clk); interrupt_ack = 1;
      @(negedge clk); interrupt_ack = 0;
      @(negedge clk); chk("ack_irq", {60'b0, interrupt_vector}, 64'h0);
      rd(KEY, d); chk("key_read", d, 64'h141);
      rd(ART, d); chk("key_status", d, 64'h0);
      chk("key_irq_off", {60'b0, interrupt_vector}, 64'h0);
      // fifo full and overflow
      for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
      rd(ART, d); chk("full_status", d, 64'h402);
      for (int i = 0; i < 4; i++) begin
         rd(KEY, d); chk("full_pop", d, 64'h110 + 64'(i));
      end
      rd(KEY, d); chk("empty_pop", d, 64'h0);
      rd(ART, d); chk("ovr_cleared", d, 64'h0);
      // push and pop together while full
      for (int i = 0; i < 4; i++) push(8'h20 + 8'(i));
      @(negedge clk); bus_address = KEY; bus_read_enable = 1;
      @(negedge clk); key_valid = 1; key_data = 8'h24;
      @(negedge clk); key_valid = 0; d = bus_read_data; bus_read_enable = 0;
      chk("pushpop_data", d, 64'h120);
      rd(ART, d); chk("pushpop_status", d, 64'h400);
      for (int i = 1; i < 5; i++) begin
         rd(KEY, d); chk("pushpop_order", d, 64'h120 + 64'(i));
      end
      // re-arm on pop
      push(8'h51); push(8'h52); idle(1);
      chk("rearm_irq", {60'b0, interrupt_vector}, 64'h1);
      @(negedge clk); interrupt_ack = 1;
      @(negedge clk); interrupt_ack = 0;
      @(negedge clk); chk("rearm_ack", {60'b0, interrupt_vector}, 64'h0);
      rd(KEY, d); chk("rearm_pop", d, 64'h151);
      chk("rearm_pre", {60'b0, interrupt_vector}, 64'h0);
      @(negedge clk); chk("rearm_post", {60'b0, interrupt_vector}, 64'h1);
      rd(KEY, d); chk("rearm_pop2", d, 64'h152);
      @(negedge clk); chk("rearm_empty", {60'b0, interrupt_vector}, 64'h0);
      // uart frame of 8'hA5 with a dropped store mid-frame
      frame = 10'b11_0100_1010;
      @(negedge clk); bus_address = ART; bus_write_data = 64'hA5; bus_write_enable = 1;
      @(negedge clk); chk("uart_pre", {63'b0, uart_tx}, 64'h1);
      @(negedge clk); bus_write_enable = 0; chk("uart_start", {63'b0, uart_tx}, 64'h0);
      @(negedge clk);
      for (int j = 0; j < 10; j++) begin
         chk("uart_bit", {63'b0, uart_tx}, {63'b0, frame[j]});
         if (j == 3) begin bus_write_data = 64'hFF; bus_write_enable = 1; end
         if (j == 4) bus_write_enable = 0;
         idle(4);
      end
      chk("uart_idle", {63'b0, uart_tx}, 64'h1);
      rd(ART, d); chk("tx_ovr", d, 64'h4);
      rd(ART, d); chk("tx_ovr_clr", d, 64'h0);
      wr(ART, 8'h3C);
      rd(ART, d); chk("tx_busy", d, 64'h1);
      idle(50);
      rd(ART, d); chk("tx_done", d, 64'h0);
      // reset mid-frame
      push(8'h77);
      wr(ART, 8'h55); idle(3);
      rd(ART, d); chk("pre_rst_status", d, 64'h101);
      idle(2);
      chk("pre_rst_irq", {60'b0, interrupt_vector}, 64'h1);
      reset = 0;
      #1;
      chk("midrst_uart", {63'b0, uart_tx}, 64'h1);
      chk("midrst_vector", {60'b0, interrupt_vector}, 64'h0);
      chk("midrst_rdata", bus_read_data, 64'h0);
      idle(2);
      reset = 1;
      rd(ART, d); chk("post_rst_status", d, 64'h0);
      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         case ($urandom_range(0, 2))
            0: bus_address = KEY;
            1: bus_address = ART;
            default: bus_address = OTH;
         endcase
         bus_write_data = {$urandom, $urandom};
         bus_read_enable = $urandom_range(0, 2) == 0;
         bus_write_enable = $urandom_range(0, 9) == 0;
         key_valid = $urandom_range(0, 3) == 0;
         key_data = 8'($urandom);
         interrupt_ack = $urandom_range(0, 9) == 0;
      end
      @(negedge clk);
      bus_read_enable = 0; bus_write_enable = 0; key_valid = 0; interrupt_ack = 0;
      idle(3);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
